// File: rtl/uart_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_frame_loader
// Description : Decodes boot-time load frames arriving as a UART byte stream
//               into 32-bit memory write requests.
//               Frame: SYNC, ADDR[31:0] LE, COUNT[15:0] LE (words),
//                      COUNT*4 payload bytes (LE words), CSUM (XOR of all
//                      bytes after SYNC).
// Ports       : i_Clock      system clock
//               i_Reset      asynchronous active-high reset
//               i_Rx_DV      one-cycle strobe, i_Rx_Byte valid
//               i_Rx_Byte    received byte
//               i_Mem_Ready  memory accepts the pending write this cycle
//               o_Mem_We     write request valid (held until accepted)
//               o_Mem_Addr   write byte address
//               o_Mem_Data   write data
//               o_Busy       frame in progress
//               o_Done       one-cycle pulse, frame completed cleanly
//               o_Error      one-cycle pulse, frame aborted / bad checksum
//               o_Err_Code   1=checksum 2=overrun 3=timeout (held)
// Revision    : 1.0  initial release
// ============================================================================
module uart_frame_loader #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Mem_Ready,
    output logic        o_Mem_We,
    output logic [31:0] o_Mem_Addr,
    output logic [31:0] o_Mem_Data,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error,
    output logic [1:0]  o_Err_Code
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ADDR = 3'd1;
    localparam logic [2:0] c_ST_LEN  = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
    localparam logic [2:0] c_ST_CSUM = 3'd4;

    localparam logic [1:0] c_ERR_CSUM    = 2'd1;
    localparam logic [1:0] c_ERR_OVERRUN = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

    localparam int                 c_TMR_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_base;
    logic [15:0]        r_count;
    logic [15:0]        r_word_idx;
    logic [23:0]        r_word;
    logic [7:0]         r_csum;
    logic [c_TMR_W-1:0] r_timer;

    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_data;
    logic               r_done;
    logic               r_error;
    logic [1:0]         r_err_code;

    logic               w_busy;
    logic               w_timeout;
    logic               w_word_done;
    logic               w_write_free;
    logic               w_overrun;
    logic               w_last_word;
    logic [15:0]        w_len_val;
    logic [7:0]         w_csum_next;

    assign w_busy       = (r_state != c_ST_IDLE);
    // A DV in the same cycle restarts the inter-byte timer, so it wins.
    assign w_timeout    = w_busy && !i_Rx_DV && (r_timer == c_TMR_LAST);
    assign w_word_done  = (r_state == c_ST_DATA) && i_Rx_DV && (r_byte_idx == 2'd3);
    // A pending write accepted in this very cycle frees the slot for the next word.
    assign w_write_free = !r_mem_we || i_Mem_Ready;
    assign w_overrun    = w_word_done && !w_write_free;
    assign w_last_word  = (r_word_idx == (r_count - 16'd1));
    assign w_len_val    = {i_Rx_Byte, r_count[15:8]};
    assign w_csum_next  = r_csum ^ i_Rx_Byte;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_timeout) begin
            w_next_state = c_ST_IDLE;
        end else if (i_Rx_DV) begin
            case (r_state)
                c_ST_IDLE: if (i_Rx_Byte == SYNC_BYTE) w_next_state = c_ST_ADDR;
                c_ST_ADDR: if (r_byte_idx == 2'd3)     w_next_state = c_ST_LEN;
                c_ST_LEN: begin
                    if (r_byte_idx == 2'd1) begin
                        w_next_state = (w_len_val == 16'd0) ? c_ST_CSUM : c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_word_done) begin
                        if (w_overrun)        w_next_state = c_ST_IDLE;
                        else if (w_last_word) w_next_state = c_ST_CSUM;
                    end
                end
                c_ST_CSUM: w_next_state = c_ST_IDLE;
                default:   w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= c_ST_IDLE;
            r_byte_idx <= 2'd0;
            r_base     <= 32'd0;
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_word     <= 24'd0;
            r_csum     <= 8'd0;
            r_timer    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_mem_data <= 32'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_state <= w_next_state;

            // Write handshake runs independently of the frame state so a
            // pending write survives an abort and is never dropped.
            if (r_mem_we && i_Mem_Ready) begin
                r_mem_we <= 1'b0;
            end

            if (!w_busy || i_Rx_DV || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TMR_ONE;
            end

            if (w_timeout) begin
                r_error    <= 1'b1;
                r_err_code <= c_ERR_TIMEOUT;
                r_byte_idx <= 2'd0;
            end else if (i_Rx_DV) begin
                // Byte index restarts on every state change; DATA wraps 3->0.
                if ((w_next_state == r_state) && (r_state != c_ST_IDLE)) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end else begin
                    r_byte_idx <= 2'd0;
                end

                case (r_state)
                    c_ST_IDLE: begin
                        r_csum <= 8'd0;
                    end
                    c_ST_ADDR: begin
                        r_base <= {i_Rx_Byte, r_base[31:8]};
                        r_csum <= w_csum_next;
                    end
                    c_ST_LEN: begin
                        r_count    <= w_len_val;
                        r_word_idx <= 16'd0;
                        r_csum     <= w_csum_next;
                    end
                    c_ST_DATA: begin
                        r_csum <= w_csum_next;
                        if (!w_word_done) begin
                            r_word <= {i_Rx_Byte, r_word[23:8]};
                        end else if (w_overrun) begin
                            r_error    <= 1'b1;
                            r_err_code <= c_ERR_OVERRUN;
                        end else begin
                            r_mem_we   <= 1'b1;
                            r_mem_data <= {i_Rx_Byte, r_word};
                            r_mem_addr <= r_base + {14'd0, r_word_idx, 2'b00};
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    c_ST_CSUM: begin
                        if (i_Rx_Byte == r_csum) begin
                            r_done     <= 1'b1;
                            r_err_code <= 2'd0;
                        end else begin
                            r_error    <= 1'b1;
                            r_err_code <= c_ERR_CSUM;
                        end
                    end
                    default: begin
                        r_csum <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign o_Mem_We   = r_mem_we;
    assign o_Mem_Addr = r_mem_addr;
    assign o_Mem_Data = r_mem_data;
    assign o_Busy     = w_busy;
    assign o_Done     = r_done;
    assign o_Error    = r_error;
    assign o_Err_Code = r_err_code;

endmodule
`default_nettype wire
